jtdsp16_sio_sched: RTL and testbench

Serial-output scheduler for the JTDSP16 serial I/O port. After reset it writes the fixed SIOC configuration, then round-robins two sample requesters (left/right channel) onto the single output shifter. For each word it issues the SRTA (address tag) write and the SDX (data) write. It waits for the shifter to drain before serving the next word. It sits between the sample sources and the SIO command inputs (long_imm, sio_imm_load, r_field) and watches the SIO obe status.

---
 rtl/jtdsp16_sio_sched.sv | 143 ++++++++++++++
 tb/tb_jtdsp16_sio_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_sio_sched.sv
// Serial-output scheduler for the JTDSP16 SIO: writes SIOC once after reset, then
// round-robins two sample requesters onto the shifter through SRTA/SDX command writes.
module jtdsp16_sio_sched #(
  parameter logic [15:0] SIOC_VAL  = 16'h02E8,
  parameter int          WBUSY_MAX = 4
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic [7:0]  addr0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] data1,
  input  logic [7:0]  addr1,
  output logic        ack1,
  input  logic        obe,
  output logic [15:0] long_imm,
  output logic        sio_imm_load,
  output logic [2:0]  r_field,
  output logic        busy,
  output logic        last_ch,
  output logic        err
);

  localparam int CW = (WBUSY_MAX > 1) ? $clog2(WBUSY_MAX) : 1;

  localparam logic [2:0] RF_SIOC = 3'b000;
  localparam logic [2:0] RF_SRTA = 3'b001;
  localparam logic [2:0] RF_SDX  = 3'b010;

  // CFG: SIOC write, IDLE: arbitrate, SRTA/SDX: command writes,
  // WBUSY: wait for obe to fall, WEMPTY: wait for the shifter to drain
  typedef enum logic [2:0] {
    CFG, IDLE, SRTA, SDX, WBUSY, WEMPTY
  } state_t;

  state_t      st_q;
  logic        ack0_q, ack1_q, ld_q, busy_q, last_ch_q, err_q;
  logic [15:0] imm_q, data_q;
  logic [2:0]  rf_q;
  logic [7:0]  addr_q, tag_q;
  logic        tag_v_q;
  logic [CW-1:0] cnt_q;

  logic        last_ch_d;
  logic [15:0] data_d;
  logic [7:0]  addr_d;

  // Grant: a lone requester wins, two requesters strictly alternate.
  always_comb begin
    last_ch_d = req1;
    if (req0 && req1) last_ch_d = ~last_ch_q;
    data_d = last_ch_d ? data1 : data0;
    addr_d = last_ch_d ? addr1 : addr0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= CFG;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      ld_q      <= 1'b0;
      imm_q     <= 16'h0000;
      rf_q      <= RF_SIOC;
      busy_q    <= 1'b0;
      last_ch_q <= 1'b1;
      err_q     <= 1'b0;
      data_q    <= 16'h0000;
      addr_q    <= 8'h00;
      tag_q     <= 8'h00;
      tag_v_q   <= 1'b0;
      cnt_q     <= '0;
    end else if (cen) begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      ld_q   <= 1'b0;
      case (st_q)
        CFG: begin
          imm_q <= SIOC_VAL;
          rf_q  <= RF_SIOC;
          ld_q  <= 1'b1;
          st_q  <= IDLE;
        end
        IDLE: begin
          if (req0 || req1) begin
            ack0_q    <= ~last_ch_d;
            ack1_q    <= last_ch_d;
            last_ch_q <= last_ch_d;
            busy_q    <= 1'b1;
            data_q    <= data_d;
            addr_q    <= addr_d;
            st_q      <= (tag_v_q && (tag_q == addr_d)) ? SDX : SRTA;
          end
        end
        SRTA: begin
          imm_q   <= {8'h00, addr_q};
          rf_q    <= RF_SRTA;
          ld_q    <= 1'b1;
          tag_q   <= addr_q;
          tag_v_q <= 1'b1;
          st_q    <= SDX;
        end
        SDX: begin
          imm_q <= data_q;
          rf_q  <= RF_SDX;
          ld_q  <= 1'b1;
          cnt_q <= CW'(WBUSY_MAX - 1);
          st_q  <= WBUSY;
        end
        WBUSY: begin
          if (!obe) begin
            st_q <= WEMPTY;
          end else if (cnt_q == '0) begin
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            st_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WEMPTY: begin
          if (obe) begin
            busy_q <= 1'b0;
            st_q   <= IDLE;
          end
        end
        default: st_q <= CFG;
      endcase
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign long_imm     = imm_q;
  assign sio_imm_load = ld_q;
  assign r_field      = rf_q;
  assign busy         = busy_q;
  assign last_ch      = last_ch_q;
  assign err          = err_q;

endmodule

// File: tb/tb_jtdsp16_sio_sched.sv
// Bench for jtdsp16_sio_sched: directed scenarios plus random traffic, checked every
// cycle against an event-schedule model of the command stream and a model SIO.
module tb_jtdsp16_sio_sched;
  localparam logic [15:0] SIOC = 16'h02E8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, obe = 1'b1;
  logic [15:0] data0 = 16'h0, data1 = 16'h0;
  logic [7:0]  addr0 = 8'h0, addr1 = 8'h0;
  logic        ack0, ack1, sio_imm_load, busy, last_ch, err;
  logic [15:0] long_imm;
  logic [2:0]  r_field;

  always #5 clk = ~clk;

  jtdsp16_sio_sched dut (
    .rst(rst), .clk(clk), .cen(cen),
    .req0(req0), .data0(data0), .addr0(addr0), .ack0(ack0),
    .req1(req1), .data1(data1), .addr1(addr1), .ack1(ack1),
    .obe(obe), .long_imm(long_imm), .sio_imm_load(sio_imm_load),
    .r_field(r_field), .busy(busy), .last_ch(last_ch), .err(err)
  );

  int n_chk = 0, n_err = 0;

  // Model: edge indices (cen edges since reset release) at which things happen.
  int ecyc, ready_e, srta_e, sdx_e, busy_e, err_e, fall_e, rise_e;
  logic [15:0] w_data;
  logic [7:0]  w_addr, tag;
  logic        tag_v;
  logic        m_ack0, m_ack1, m_ld, m_busy, m_last, m_err;
  logic [15:0] m_imm;
  logic [2:0]  m_rf;
  bit          to_mode;
  int          k_d, k_L;

  int dlog[$];
  int ack_cyc = -100, srta_cyc = -100, sdx_cyc = -100, err_cyc = -100;
  bit err_seen = 0;

  task automatic check(input string tag_s, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag_s, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ecyc = 0; ready_e = 2; srta_e = -1; sdx_e = -1; busy_e = -1; err_e = -1;
    fall_e = 0; rise_e = 0; tag_v = 0; tag = 8'h00;
    m_ack0 = 0; m_ack1 = 0; m_ld = 0; m_imm = 16'h0; m_rf = 3'd0;
    m_busy = 0; m_last = 1; m_err = 0;
  endtask

  task automatic model_edge();
    bit ch;
    ecyc++;
    m_ack0 = 0; m_ack1 = 0; m_ld = 0;
    if (ecyc == 1) begin m_ld = 1; m_rf = 3'd0; m_imm = SIOC; end
    if (ecyc == srta_e) begin m_ld = 1; m_rf = 3'd1; m_imm = {8'h00, w_addr}; end
    if (ecyc == sdx_e) begin m_ld = 1; m_rf = 3'd2; m_imm = w_data; end
    if (ecyc == busy_e) m_busy = 0;
    if (ecyc == err_e) begin m_err = 1; m_busy = 0; end
    if (ecyc >= ready_e && (req0 || req1)) begin
      ch = (req0 && req1) ? !m_last : req1;
      m_ack0 = !ch; m_ack1 = ch; m_last = ch; m_busy = 1;
      w_data = ch ? data1 : data0;
      w_addr = ch ? addr1 : addr0;
      if (tag_v && tag == w_addr) begin
        srta_e = -1; sdx_e = ecyc + 1;
      end else begin
        srta_e = ecyc + 1; sdx_e = ecyc + 2; tag = w_addr; tag_v = 1;
      end
      if (to_mode) begin
        fall_e = 0; busy_e = -1; err_e = sdx_e + 4; ready_e = err_e + 1;
      end else begin
        fall_e = sdx_e + k_d; rise_e = fall_e + k_L;
        busy_e = rise_e; err_e = -1; ready_e = rise_e + 1;
      end
    end
  endtask

  task automatic check_all();
    check("ack0", ack0, m_ack0);
    check("ack1", ack1, m_ack1);
    check("strobe", sio_imm_load, m_ld);
    check("long_imm", long_imm, m_imm);
    check("r_field", r_field, m_rf);
    check("busy", busy, m_busy);
    check("last_ch", last_ch, m_last);
    check("err", err, m_err);
  endtask

  // One clock: drive the model SIO's obe, let the edge happen, compare, then
  // drop any request the scheduler just accepted.
  task automatic step();
    bit ce;
    int n;
    n = ecyc + 1;
    obe = !(fall_e > 0 && n >= fall_e && n < rise_e);
    ce = cen && !rst;
    @(posedge clk);
    if (ce) model_edge();
    #1;
    check_all();
    if (ce) begin
      if (ack0) dlog.push_back(0);
      if (ack1) dlog.push_back(1);
      if (ack0 || ack1) ack_cyc = ecyc;
      if (sio_imm_load && r_field == 3'd1) srta_cyc = ecyc;
      if (sio_imm_load && r_field == 3'd2) sdx_cyc = ecyc;
      if (err && !err_seen) begin err_seen = 1; err_cyc = ecyc; end
    end
    @(negedge clk);
    if (ce && m_ack0) req0 = 1'b0;
    if (ce && m_ack1) req1 = 1'b0;
  endtask

  task automatic wait_ack(input int budget);
    int n0, i;
    n0 = dlog.size(); i = 0;
    while (dlog.size() == n0 && i < budget) begin step(); i++; end
    check("ack_wait", dlog.size() > n0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((busy || ecyc + 1 < ready_e) && i < budget) begin step(); i++; end
    check("idle_wait", busy, 0);
  endtask

  task automatic serve();
    wait_ack(20);
    wait_idle(300);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, r, i;
    model_reset();
    to_mode = 0; k_d = 1; k_L = 10;
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();

    // both requesters held with distinct tags: strict alternation from channel 0
    b = dlog.size();
    req0 = 1; data0 = 16'hA000; addr0 = 8'h10;
    req1 = 1; data1 = 16'hB000; addr1 = 8'h90;
    for (int w = 0; w < 4; w++) begin
      k_d = 1 + w; k_L = 8 + w;
      serve();
      if (!req0) begin req0 = 1; addr0 = 8'(8'h11 + w); data0 = 16'($urandom); end
      if (!req1) begin req1 = 1; addr1 = 8'(8'h91 + w); data1 = 16'($urandom); end
    end
    for (int w = 0; w < 4; w++)
      check("alt_order", (dlog.size() > b + w) ? dlog[b + w] : -1, w % 2);
    req0 = 0; req1 = 0;
    step();

    // single word on channel 0
    r = ecyc; data0 = 16'h1234; addr0 = 8'h80; req0 = 1; k_d = 1; k_L = 30;
    serve();
    check("p1_ack_lat", ack_cyc - r, 1);
    check("p1_srta_lat", srta_cyc - r, 2);
    check("p1_sdx_lat", sdx_cyc - r, 3);

    // two words on channel 1 with the same tag: second skips SRTA
    data1 = 16'($urandom); addr1 = 8'h00; req1 = 1; k_d = 2; k_L = 15;
    serve();
    r = ecyc; data1 = 16'($urandom); addr1 = 8'h00; req1 = 1; k_d = 3;
    serve();
    check("skip_ack_lat", ack_cyc - r, 1);
    check("skip_sdx_lat", sdx_cyc - r, 2);
    check("skip_no_srta", srta_cyc < r, 1);

    // obe never falls: timeout, then the port keeps serving
    to_mode = 1; data0 = 16'hDEAD; addr0 = 8'h44; req0 = 1;
    serve();
    check("to_err_lat", err_cyc - sdx_cyc, 4);
    to_mode = 0; k_d = 4; k_L = 12; data1 = 16'hBEEF; addr1 = 8'h45; req1 = 1;
    serve();
    check("to_next_served", (dlog.size() > 0) ? dlog[$] : -1, 1);
    check("to_err_sticky", err, 1);

    // reset while draining: back to CFG, tag forgotten
    k_d = 2; k_L = 20; data0 = 16'h5555; addr0 = 8'h55; req0 = 1;
    wait_ack(20);
    i = 0;
    while (ecyc < fall_e + 2 && i < 100) begin step(); i++; end
    check("wempty_busy", busy, 1);
    rst = 1'b1; model_reset(); err_seen = 0;
    #1;
    check_all();
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    r = ecyc; data0 = 16'h6666; addr0 = 8'h55; req0 = 1; k_d = 1; k_L = 10;
    serve();
    check("rst_srta_lat", srta_cyc - r, 2);

    // random traffic with gated cen, tag reuse, abandoned requests and timeouts
    for (int c = 0; c < 3000; c++) begin
      cen = ($urandom_range(0, 99) < 85);
      to_mode = ($urandom_range(0, 9) == 0);
      k_d = $urandom_range(1, 4);
      k_L = $urandom_range(1, 40);
      if (!req0 && $urandom_range(0, 7) == 0) begin
        req0 = 1; data0 = 16'($urandom); addr0 = 8'($urandom_range(0, 3));
      end else if (req0 && $urandom_range(0, 49) == 0) begin
        req0 = 0;
      end
      if (!req1 && $urandom_range(0, 7) == 0) begin
        req1 = 1; data1 = 16'($urandom); addr1 = 8'($urandom_range(0, 3));
      end else if (req1 && $urandom_range(0, 49) == 0) begin
        req1 = 0;
      end
      step();
    end
    cen = 1; req0 = 0; req1 = 0;
    wait_idle(300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
